// File: rtl/mem_access_if.sv
// Data-bus bundle between the memory-stage access unit (master) and the data memory (slave).
interface mem_access_if #(
  parameter int XLEN = 64
);
  logic            dreq_valid;
  logic [XLEN-1:0] dreq_addr;
  logic [2:0]      dreq_size;
  logic [7:0]      dreq_strobe;
  logic [XLEN-1:0] dreq_data;
  logic            dresp_addr_ok;
  logic            dresp_data_ok;
  logic [XLEN-1:0] dresp_data;

  modport master (
    output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    input  dresp_addr_ok, dresp_data_ok, dresp_data
  );

  modport slave (
    input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    output dresp_addr_ok, dresp_data_ok, dresp_data
  );
endinterface

// File: rtl/mem_access.sv
// Memory-stage load/store unit: issues aligned bus requests with byte strobes, stalls the
// pipeline while a transaction is outstanding, and extends returned load data to XLEN.
module mem_access #(
  parameter int XLEN        = 64,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic            in_load,
  input  logic            in_store,
  input  logic [1:0]      in_size,
  input  logic            in_unsigned,
  input  logic [XLEN-1:0] in_addr,
  input  logic [XLEN-1:0] in_wdata,
  input  logic            flush,
  output logic            in_ready,
  output logic            stall,
  mem_access_if.master    bus,
  output logic            out_valid,
  output logic [XLEN-1:0] out_rdata,
  output logic            out_misalign,
  output logic [1:0]      dbg_state
);
  // Bus handshake: a request is held on dreq_* while dreq_valid=1 until dresp_addr_ok is seen
  // at a rising edge; dresp_data/dresp_data_ok are sampled at the edge that ends the data phase.
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [1:0]      size_q, size_d;
  logic [7:0]      strobe_q, strobe_d;
  logic            load_q, load_d, uns_q, uns_d, flush_q, flush_d;
  logic            out_valid_q, out_valid_d, out_mis_q, out_mis_d;
  logic [XLEN-1:0] out_rdata_q, out_rdata_d;

  logic            accept, is_mem, misalign, finish, discard;
  logic [7:0]      strobe_base;
  logic [2:0]      align_mask;
  logic [XLEN-1:0] shifted, load_ext;

  assign accept = in_valid && in_ready && !flush;
  assign is_mem = in_load || in_store;

  always_comb begin
    strobe_base = 8'h01;
    align_mask  = 3'b000;
    case (in_size)
      2'd0: begin strobe_base = 8'h01; align_mask = 3'b000; end
      2'd1: begin strobe_base = 8'h03; align_mask = 3'b001; end
      2'd2: begin strobe_base = 8'h0F; align_mask = 3'b011; end
      default: begin strobe_base = 8'hFF; align_mask = 3'b111; end
    endcase
  end

  assign misalign = CHECK_ALIGN && ((in_addr[2:0] & align_mask) != 3'b000);

  // Loads select their lane by shifting the raw 8-byte word down by the byte offset.
  assign shifted = bus.dresp_data >> {addr_q[2:0], 3'b000};

  always_comb begin
    load_ext = shifted;
    case (size_q)
      2'd0: load_ext = uns_q ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                             : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      2'd1: load_ext = uns_q ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                             : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      2'd2: load_ext = uns_q ? {{(XLEN-32){1'b0}}, shifted[31:0]}
                             : {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      default: load_ext = shifted;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    strobe_d    = strobe_q;
    load_d      = load_q;
    uns_d       = uns_q;
    flush_d     = flush_q;
    out_valid_d = 1'b0;
    out_mis_d   = 1'b0;
    out_rdata_d = '0;
    finish      = 1'b0;
    discard     = flush_q || flush;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!is_mem || misalign) begin
            out_valid_d = 1'b1;
            out_mis_d   = is_mem;
          end else begin
            state_d  = REQ;
            addr_d   = in_addr;
            size_d   = in_size;
            load_d   = in_load;
            uns_d    = in_unsigned;
            strobe_d = in_store ? (strobe_base << in_addr[2:0]) : 8'h00;
            wdata_d  = in_wdata << {in_addr[2:0], 3'b000};
          end
        end
      end
      REQ: begin
        flush_d = discard;
        if (bus.dresp_addr_ok) begin
          if (bus.dresp_data_ok) finish = 1'b1;
          else                   state_d = WAIT;
        end
      end
      WAIT: begin
        flush_d = discard;
        if (bus.dresp_data_ok) finish = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // A flush seen at any point of the transaction suppresses its result pulse.
    if (finish) begin
      state_d     = IDLE;
      flush_d     = 1'b0;
      out_valid_d = !discard;
      out_rdata_d = (load_q && !discard) ? load_ext : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      size_q      <= 2'd0;
      strobe_q    <= 8'h00;
      load_q      <= 1'b0;
      uns_q       <= 1'b0;
      flush_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_mis_q   <= 1'b0;
      out_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      strobe_q    <= strobe_d;
      load_q      <= load_d;
      uns_q       <= uns_d;
      flush_q     <= flush_d;
      out_valid_q <= out_valid_d;
      out_mis_q   <= out_mis_d;
      out_rdata_q <= out_rdata_d;
    end
  end

  assign in_ready        = (state_q == IDLE);
  assign stall           = (state_q != IDLE);
  assign bus.dreq_valid  = (state_q == REQ);
  assign bus.dreq_addr   = addr_q;
  assign bus.dreq_size   = {1'b0, size_q};
  assign bus.dreq_strobe = strobe_q;
  assign bus.dreq_data   = wdata_q;
  assign out_valid       = out_valid_q;
  assign out_rdata       = out_rdata_q;
  assign out_misalign    = out_mis_q;
  assign dbg_state       = state_q;
endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed loads/stores against a behavioural model of
// lane selection, strobes and extension, with a per-cycle compare process.
module tb_mem_access;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_load, in_store, in_unsigned, flush;
  logic [1:0]  in_size;
  logic [63:0] in_addr, in_wdata;
  logic        in_ready, stall, out_valid, out_misalign;
  logic [63:0] out_rdata;
  logic [1:0]  dbg_state;

  mem_access_if #(.XLEN(64)) bus ();

  mem_access #(.XLEN(64), .CHECK_ALIGN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_load(in_load), .in_store(in_store), .in_size(in_size),
    .in_unsigned(in_unsigned), .in_addr(in_addr), .in_wdata(in_wdata), .flush(flush),
    .in_ready(in_ready), .stall(stall), .bus(bus),
    .out_valid(out_valid), .out_rdata(out_rdata), .out_misalign(out_misalign),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [64:0] exp_q[$];      // {misalign, rdata} per expected result pulse
  bit          exp_active = 1'b0;
  bit          exp_store;
  logic [63:0] exp_addr, exp_data;
  logic [2:0]  exp_size;
  logic [7:0]  exp_strobe;
  logic [7:0]  last_strobe;
  logic [63:0] last_data;
  int          req_cycles;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] m_load(input logic [63:0] d, input logic [63:0] a,
                                          input int sz, input bit uns);
    int nbits;
    logic [63:0] r, mask;
    nbits = 8 << sz;
    r = d >> (8 * a[2:0]);
    mask = (nbits == 64) ? {64{1'b1}} : ((64'd1 << nbits) - 64'd1);
    r = r & mask;
    if (!uns && nbits < 64 && r[nbits-1]) r = r | ~mask;
    return r;
  endfunction

  function automatic logic [7:0] m_strobe(input int sz, input logic [63:0] a);
    logic [15:0] s;
    s = ((16'd1 << (1 << sz)) - 16'd1) << a[2:0];
    return s[7:0];
  endfunction

  // Compare process: result pulses against the scoreboard, live requests against the model.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", {63'd0, out_valid}, 64'd0);
        end else begin
          logic [64:0] e;
          e = exp_q.pop_front();
          check("out_rdata", out_rdata, e[63:0]);
          check("out_misalign", {63'd0, out_misalign}, {63'd0, e[64]});
        end
      end
      if (bus.dreq_valid) begin
        if (!exp_active) begin
          check("unexpected_dreq_valid", 64'd1, 64'd0);
        end else begin
          check("dreq_addr", bus.dreq_addr, exp_addr);
          check("dreq_size", {61'd0, bus.dreq_size}, {61'd0, exp_size});
          check("dreq_strobe", {56'd0, bus.dreq_strobe}, {56'd0, exp_strobe});
          if (exp_store) check("dreq_data", bus.dreq_data, exp_data);
        end
      end
      check("ready_vs_stall", {63'd0, in_ready}, {63'd0, ~stall});
    end
  end

  task automatic drive_op(input bit ld, input bit st, input logic [1:0] sz, input bit uns,
                          input logic [63:0] addr, input logic [63:0] wdata);
    in_valid = 1'b1; in_load = ld; in_store = st; in_size = sz;
    in_unsigned = uns; in_addr = addr; in_wdata = wdata;
  endtask

  // One operation from accept to result; returns #1 into the cycle the result pulse is due.
  task automatic mem_op(input bit ld, input bit st, input logic [1:0] sz, input bit uns,
                        input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [63:0] rdat, input int a_dly, input int d_dly,
                        input bit flush_wait);
    bit mem, mis;
    mem = ld || st;
    mis = mem && ((addr & ((64'd1 << sz) - 64'd1)) != 64'd0);
    @(posedge clk); #1;
    check("in_ready_idle", {63'd0, in_ready}, 64'd1);
    drive_op(ld, st, sz, uns, addr, wdata);
    if (mem && !mis) begin
      exp_active = 1'b1; exp_store = st; exp_addr = addr; exp_size = {1'b0, sz};
      exp_strobe = st ? m_strobe(int'(sz), addr) : 8'h00;
      exp_data   = wdata << (8 * addr[2:0]);
    end else begin
      exp_q.push_back({mis, 64'd0});
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (!mem || mis) begin
      check("no_request", {63'd0, bus.dreq_valid}, 64'd0);
      check("early_pulse", {63'd0, out_valid}, 64'd1);
      return;
    end
    for (int i = 0; i < a_dly; i++) begin
      check("req_wait_valid", {63'd0, bus.dreq_valid}, 64'd1);
      check("req_wait_stall", {63'd0, stall}, 64'd1);
      req_cycles++;
      @(posedge clk); #1;
    end
    check("req_valid", {63'd0, bus.dreq_valid}, 64'd1);
    req_cycles++;
    last_strobe = bus.dreq_strobe;
    last_data   = bus.dreq_data;
    if (!flush_wait) exp_q.push_back({1'b0, ld ? m_load(rdat, addr, int'(sz), uns) : 64'd0});
    bus.dresp_addr_ok = 1'b1;
    if (d_dly == 0) begin
      bus.dresp_data_ok = 1'b1;
      bus.dresp_data    = rdat;
    end
    @(posedge clk); #1;
    bus.dresp_addr_ok = 1'b0;
    bus.dresp_data_ok = 1'b0;
    bus.dresp_data    = 64'hDEAD_BEEF_DEAD_BEEF;
    if (d_dly > 0) begin
      for (int i = 1; i < d_dly; i++) begin
        if (flush_wait && i == 1) flush = 1'b1;
        check("wait_no_valid", {63'd0, bus.dreq_valid}, 64'd0);
        check("wait_stall", {63'd0, stall}, 64'd1);
        @(posedge clk); #1;
        flush = 1'b0;
      end
      check("data_phase_stall", {63'd0, stall}, 64'd1);
      bus.dresp_data_ok = 1'b1;
      bus.dresp_data    = rdat;
      @(posedge clk); #1;
      bus.dresp_data_ok = 1'b0;
      bus.dresp_data    = 64'hDEAD_BEEF_DEAD_BEEF;
    end
    exp_active = 1'b0;
    check("done_ready", {63'd0, in_ready}, 64'd1);
    check("done_pulse", {63'd0, out_valid}, flush_wait ? 64'd0 : 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0; in_size = 2'd0;
    in_unsigned = 1'b0; in_addr = '0; in_wdata = '0; flush = 1'b0;
    bus.dresp_addr_ok = 1'b0; bus.dresp_data_ok = 1'b0; bus.dresp_data = '0;
    req_cycles = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_stall", {63'd0, stall}, 64'd0);
    check("rst_dreq_valid", {63'd0, bus.dreq_valid}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_strobe", {56'd0, bus.dreq_strobe}, 64'd0);
    check("rst_rdata", out_rdata, 64'd0);
    reset = 1'b0;

    // lw with sign extension, single-cycle bus
    mem_op(1, 0, 2'd2, 0, 64'h1004, 64'd0, 64'h8000_0001_0000_0000, 0, 0, 0);
    check("lw_literal", out_rdata, 64'hFFFF_FFFF_8000_0001);

    // sb into lane 3
    mem_op(0, 1, 2'd0, 0, 64'h1003, 64'hAB, 64'd0, 0, 0, 0);
    check("sb_strobe", {56'd0, last_strobe}, 64'h08);
    check("sb_lane", {56'd0, last_data[31:24]}, 64'hAB);
    check("sb_rdata", out_rdata, 64'd0);

    // misaligned lh
    mem_op(1, 0, 2'd1, 0, 64'h1001, 64'd0, 64'd0, 0, 0, 0);
    check("lh_misalign", {63'd0, out_misalign}, 64'd1);

    // ld with slow bus
    req_cycles = 0;
    mem_op(1, 0, 2'd3, 0, 64'h2000, 64'd0, 64'h0123_4567_89AB_CDEF, 3, 2, 0);
    check("ld_req_cycles", 64'(req_cycles), 64'd4);
    check("ld_rdata", out_rdata, 64'h0123_4567_89AB_CDEF);

    // lbu / lb from lane 5
    mem_op(1, 0, 2'd0, 1, 64'h3005, 64'd0, 64'h0000_FF00_0000_0000, 1, 1, 0);
    check("lbu_literal", out_rdata, 64'hFF);
    mem_op(1, 0, 2'd0, 0, 64'h3005, 64'd0, 64'h0000_FF00_0000_0000, 0, 0, 0);
    check("lb_literal", out_rdata, 64'hFFFF_FFFF_FFFF_FFFF);

    // flush while waiting for data
    mem_op(1, 0, 2'd2, 0, 64'h1008, 64'd0, 64'h1111_2222_3333_4444, 0, 3, 1);

    // non-memory op
    mem_op(0, 0, 2'd3, 0, 64'h7777, 64'd0, 64'd0, 0, 0, 0);
    check("nonmem_rdata", out_rdata, 64'd0);

    // halfword store, word unsigned load, dword store
    mem_op(0, 1, 2'd1, 0, 64'h4006, 64'h1234, 64'd0, 0, 1, 0);
    check("sh_strobe", {56'd0, last_strobe}, 64'hC0);
    check("sh_data", last_data, 64'h1234_0000_0000_0000);
    mem_op(1, 0, 2'd2, 1, 64'h400C, 64'd0, 64'hF00D_CAFE_0000_0000, 2, 0, 0);
    check("lwu_literal", out_rdata, 64'h0000_0000_F00D_CAFE);
    mem_op(0, 1, 2'd3, 0, 64'h4008, 64'hA5A5_5A5A_0F0F_F0F0, 64'd0, 1, 2, 0);
    check("sd_strobe", {56'd0, last_strobe}, 64'hFF);

    // flush with in_valid in IDLE: nothing accepted
    @(posedge clk); #1;
    drive_op(1, 0, 2'd2, 0, 64'h5000, 64'd0);
    flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_idle_req", {63'd0, bus.dreq_valid}, 64'd0);
    check("flush_idle_pulse", {63'd0, out_valid}, 64'd0);
    check("flush_idle_ready", {63'd0, in_ready}, 64'd1);

    // stray data_ok in IDLE
    bus.dresp_data_ok = 1'b1;
    @(posedge clk); #1;
    bus.dresp_data_ok = 1'b0;
    @(posedge clk); #1;
    check("stray_data_ok", {63'd0, out_valid}, 64'd0);

    // async reset during REQ
    drive_op(1, 0, 2'd3, 0, 64'h6000, 64'd0);
    exp_active = 1'b1; exp_store = 1'b0; exp_addr = 64'h6000; exp_size = 3'd3; exp_strobe = 8'h00;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre_reset_req", {63'd0, bus.dreq_valid}, 64'd1);
    #1 reset = 1'b1;
    #1;
    check("async_reset_req", {63'd0, bus.dreq_valid}, 64'd0);
    check("async_reset_state", {62'd0, dbg_state}, 64'd0);
    check("async_reset_ready", {63'd0, in_ready}, 64'd1);
    exp_active = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    // a normal op still works after reset
    mem_op(1, 0, 2'd1, 0, 64'h6002, 64'd0, 64'h0000_0000_8001_0000, 0, 0, 0);
    check("lh_after_reset", out_rdata, 64'hFFFF_FFFF_FFFF_8001);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
